// File: rtl/ct_mmu_iutlb_entry_array.sv
// ct_mmu_iutlb_entry_array: fully-associative instruction micro-TLB with ASID/global tagging, victim selection and invalidation
module ct_mmu_iutlb_entry_array #(
  parameter int ENTRY_NUM    = 4,
  parameter int VPN_WIDTH    = 27,
  parameter int PPN_WIDTH    = 28,
  parameter int FLG_WIDTH    = 14,
  parameter int PGS_WIDTH    = 3,
  parameter int ASID_WIDTH   = 16,
  parameter int INV_CMP_BITS = 8,
  parameter int IDX_W        = $clog2(ENTRY_NUM)
) (
  input  logic                  utlb_entry_clk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  input  logic [VPN_WIDTH-1:0]  req_vpn,
  input  logic [ASID_WIDTH-1:0] req_asid,
  output logic                  rsp_vld,
  output logic                  rsp_hit,
  output logic                  rsp_multi_hit,
  output logic [IDX_W-1:0]      rsp_idx,
  output logic [PPN_WIDTH-1:0]  rsp_ppn,
  output logic [PGS_WIDTH-1:0]  rsp_pgs,
  output logic [FLG_WIDTH-1:0]  rsp_flg,
  input  logic                  upd_vld,
  input  logic [VPN_WIDTH-1:0]  upd_vpn,
  input  logic [PPN_WIDTH-1:0]  upd_ppn,
  input  logic [PGS_WIDTH-1:0]  upd_pgs,
  input  logic [FLG_WIDTH-1:0]  upd_flg,
  input  logic [ASID_WIDTH-1:0] upd_asid,
  input  logic                  upd_glb,
  output logic [IDX_W-1:0]      upd_idx,
  input  logic                  inv_all,
  input  logic                  inv_asid_req,
  input  logic [ASID_WIDTH-1:0] inv_asid,
  input  logic                  inv_va_req,
  input  logic [VPN_WIDTH-1:0]  inv_va,
  output logic [ENTRY_NUM-1:0]  entry_vld
);
  logic [VPN_WIDTH-1:0]  e_vpn  [ENTRY_NUM];
  logic [PPN_WIDTH-1:0]  e_ppn  [ENTRY_NUM];
  logic [FLG_WIDTH-1:0]  e_flg  [ENTRY_NUM];
  logic [PGS_WIDTH-1:0]  e_pgs  [ENTRY_NUM];
  logic [ASID_WIDTH-1:0] e_asid [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]  vld, glb, hit, inv;
  logic [IDX_W-1:0]      rr_ptr, hit_idx, free_idx;
  logic                  multi;
  assign entry_vld = vld;
  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    assign hit[i] = vld[i] & (glb[i] | (e_asid[i] == req_asid)) &
                    ((e_pgs[i][0] & (e_vpn[i] == req_vpn)) |
                     (e_pgs[i][1] & (e_vpn[i][VPN_WIDTH-1:9] == req_vpn[VPN_WIDTH-1:9])) |
                     (e_pgs[i][2] & (e_vpn[i][VPN_WIDTH-1:18] == req_vpn[VPN_WIDTH-1:18])));
    assign inv[i] = inv_all | (inv_asid_req & ~glb[i] & (e_asid[i] == inv_asid)) |
                    (inv_va_req & (e_vpn[i][INV_CMP_BITS-1:0] == inv_va[INV_CMP_BITS-1:0]));
  end
  assign multi   = $countones(hit) > 1;
  assign upd_idx = &vld ? rr_ptr : free_idx;
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
      hit_idx  = hit[k] ? IDX_W'(k) : hit_idx;
      free_idx = !vld[k] ? IDX_W'(k) : free_idx;
    end
  end
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld    <= '0;
      glb    <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < ENTRY_NUM; k++) begin
        e_vpn[k]  <= '0;
        e_ppn[k]  <= '0;
        e_flg[k]  <= '0;
        e_pgs[k]  <= '0;
        e_asid[k] <= '0;
      end
    end else begin
      // refill wins on its own index unless everything is being flushed
      for (int k = 0; k < ENTRY_NUM; k++)
        vld[k] <= inv_all ? 1'b0 : (upd_vld && upd_idx == IDX_W'(k)) ? 1'b1 : vld[k] & ~inv[k];
      if (upd_vld) begin
        e_vpn[upd_idx]  <= upd_vpn;
        e_ppn[upd_idx]  <= upd_ppn;
        e_flg[upd_idx]  <= upd_flg;
        e_pgs[upd_idx]  <= upd_pgs;
        e_asid[upd_idx] <= upd_asid;
        glb[upd_idx]    <= upd_glb;
      end
      if (upd_vld && &vld) rr_ptr <= rr_ptr + 1'b1;
    end
  end
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld       <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_multi_hit <= 1'b0;
      rsp_idx       <= '0;
      rsp_ppn       <= '0;
      rsp_pgs       <= '0;
      rsp_flg       <= '0;
    end else begin
      rsp_vld <= req_vld;
      if (req_vld) begin
        rsp_hit       <= |hit;
        rsp_multi_hit <= multi;
        rsp_idx       <= hit_idx;
        rsp_ppn       <= |hit ? e_ppn[hit_idx] : '0;
        rsp_pgs       <= |hit ? e_pgs[hit_idx] : '0;
        rsp_flg       <= |hit ? e_flg[hit_idx] : '0;
      end
    end
  end
endmodule
